// File: rtl/jtcontra_layer_mix.sv
// N-layer colour mixer for 007121-based boards.
// Resolves transparency and a per-line latched priority between up to four
// layer pixel streams. The winner indexes a CPU-accessible palette RAM, and
// the palette word becomes registered 5-bit RGB with matching delayed blanking.
// The pipeline is three pxl_cen ticks deep: select, palette read, colour.
module jtcontra_layer_mix #(
    parameter int LAYERS = 2,
    parameter int PXLW   = 7,
    parameter int LW     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pxl_cen,
    input  logic                   LHBL,
    input  logic                   LVBL,
    output logic                   LHBL_dly,
    output logic                   LVBL_dly,
    input  logic [LAYERS*PXLW-1:0] pxl_in,
    input  logic [LAYERS*2-1:0]    prio,
    input  logic [LAYERS-1:0]      gfx_en,
    input  logic                   cpu_cen,
    input  logic                   pal_cs,
    input  logic                   cpu_rnw,
    input  logic [LW+PXLW:0]       cpu_addr,
    input  logic [7:0]             cpu_dout,
    output logic [7:0]             pal_dout,
    output logic [4:0]             red,
    output logic [4:0]             green,
    output logic [4:0]             blue
);

    localparam int AW    = LW + PXLW;
    localparam int DEPTH = 1 << AW;

    // Palette is split into low/high byte arrays so each byte lane has its own
    // write enable while both still map onto one dual-port block RAM.
    logic [7:0] pal_lo [DEPTH];
    logic [7:0] pal_hi [DEPTH];

    logic [LAYERS*2-1:0] prio_latch;
    logic                hb_last;
    logic [LAYERS-1:0]   opaque;

    logic [AW-1:0]       sel_idx;
    logic                win_found;
    logic [1:0]          win_rank;
    logic [LW-1:0]       win_id;
    logic [PXLW-1:0]     win_pxl;

    logic [AW-1:0]       idx_reg;
    logic [14:0]         vid_word;
    logic [1:0]          hb_pipe;
    logic [1:0]          vb_pipe;

    logic [AW-1:0]       cpu_word;
    logic                cpu_wr;

    assign cpu_word = cpu_addr[AW:1];
    assign cpu_wr   = pal_cs & ~cpu_rnw & cpu_cen;

    // A layer is transparent when its colour code is zero or it is disabled.
    genvar gi;
    generate
        for (gi = 0; gi < LAYERS; gi++) begin : g_opaque
            assign opaque[gi] = gfx_en[gi] && (pxl_in[gi*PXLW +: 4] != 4'd0);
        end
    endgenerate

    // Pick the opaque layer with the lowest latched rank; strict compare keeps
    // the lower index on ties because layers are scanned in ascending order.
    always_comb begin
        win_found = 1'b0;
        win_rank  = 2'd3;
        win_id    = '0;
        win_pxl   = '0;
        for (int k = 0; k < LAYERS; k++) begin
            if (opaque[k] && (!win_found || prio_latch[k*2 +: 2] < win_rank)) begin
                win_found = 1'b1;
                win_rank  = prio_latch[k*2 +: 2];
                win_id    = LW'(k);
                win_pxl   = pxl_in[k*PXLW +: PXLW];
            end
        end
        sel_idx = win_found ? {win_id, win_pxl} : '0;
    end

    // Priority latch follows the line start (LHBL falling) so a mid-line prio
    // change only affects the next line; stage 1 registers the palette index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < LAYERS; k++) begin
                prio_latch[k*2 +: 2] <= 2'(k);
            end
            hb_last <= 1'b0;
            idx_reg <= '0;
        end else if (pxl_cen) begin
            hb_last <= LHBL;
            if (hb_last && !LHBL) begin
                prio_latch <= prio;
            end
            idx_reg <= sel_idx;
        end
    end

    // Palette RAM: CPU byte writes and the video read port. The video read sees
    // the pre-write contents when both touch the same word in one clock.
    always_ff @(posedge clk) begin
        if (cpu_wr && !cpu_addr[0]) begin
            pal_lo[cpu_word] <= cpu_dout;
        end
        if (cpu_wr && cpu_addr[0]) begin
            pal_hi[cpu_word] <= cpu_dout;
        end
        if (pxl_cen) begin
            vid_word <= {pal_hi[idx_reg][6:0], pal_lo[idx_reg]};
        end
    end

    // CPU read-back register: follows the address while selected, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pal_dout <= 8'd0;
        end else if (pal_cs) begin
            pal_dout <= cpu_addr[0] ? pal_hi[cpu_word] : pal_lo[cpu_word];
        end
    end

    // Blank delay line and output colour stage; colour is gated by the blank
    // value that travels alongside it so RGB and *_dly stay aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_pipe  <= 2'b00;
            vb_pipe  <= 2'b00;
            LHBL_dly <= 1'b0;
            LVBL_dly <= 1'b0;
            red      <= 5'd0;
            green    <= 5'd0;
            blue     <= 5'd0;
        end else if (pxl_cen) begin
            hb_pipe  <= {hb_pipe[0], LHBL};
            vb_pipe  <= {vb_pipe[0], LVBL};
            LHBL_dly <= hb_pipe[1];
            LVBL_dly <= vb_pipe[1];
            if (hb_pipe[1] && vb_pipe[1]) begin
                red   <= vid_word[4:0];
                green <= vid_word[9:5];
                blue  <= vid_word[14:10];
            end else begin
                red   <= 5'd0;
                green <= 5'd0;
                blue  <= 5'd0;
            end
        end
    end

endmodule

// File: tb/tb_jtcontra_layer_mix.sv
// Directed bench for jtcontra_layer_mix (LAYERS=2, PXLW=7, LW=2).
// Video expectations go through a two-stage scoreboard: pixel entries are
// queued when driven, resolved to a colour against a shadow palette at the
// tick the RAM is read, then compared when they reach the outputs.
module tb_jtcontra_layer_mix;

    logic        clk = 1'b0;
    logic        rst;
    logic        pxl_cen;
    logic        LHBL, LVBL;
    logic        LHBL_dly, LVBL_dly;
    logic [13:0] pxl_in;
    logic [3:0]  prio;
    logic [1:0]  gfx_en;
    logic        cpu_cen, pal_cs, cpu_rnw;
    logic [9:0]  cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  pal_dout;
    logic [4:0]  red, green, blue;

    jtcontra_layer_mix #(.LAYERS(2), .PXLW(7), .LW(2)) dut (
        .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
        .LHBL(LHBL), .LVBL(LVBL), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
        .pxl_in(pxl_in), .prio(prio), .gfx_en(gfx_en),
        .cpu_cen(cpu_cen), .pal_cs(pal_cs), .cpu_rnw(cpu_rnw),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .pal_dout(pal_dout),
        .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [8:0] idx; logic hb; logic vb; } ent_t;
    typedef struct packed { logic [4:0] r; logic [4:0] g; logic [4:0] b; logic hb; logic vb; } out_t;

    ent_t        idxq[$];
    out_t        rgbq[$];
    logic [15:0] shadow [512];
    logic [3:0]  prio_m;
    logic        hb_last_m;
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_tick   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference selection: scan ranks from top, then layers, first opaque hit wins.
    function automatic logic [8:0] model_idx(input logic [13:0] px, input logic [3:0] pr,
                                             input logic [1:0] en);
        for (int r = 0; r < 4; r++) begin
            for (int l = 0; l < 2; l++) begin
                if (pr[l*2 +: 2] == 2'(r) && en[l] && px[l*7 +: 4] != 4'd0)
                    return {2'(l), px[l*7 +: 7]};
            end
        end
        return 9'd0;
    endfunction

    task automatic model_reset();
        ent_t e0;
        out_t o0;
        prio_m    = 4'b0100;
        hb_last_m = 1'b0;
        idxq.delete();
        rgbq.delete();
        e0 = '0;
        o0 = '0;
        idxq.push_back(e0);
        rgbq.push_back(o0);
    endtask

    // One pxl_cen tick followed by one idle clock; optional CPU write in the tick clock.
    task automatic tick(input bit do_wr, input logic [9:0] wa, input logic [7:0] wd);
        ent_t        e;
        ent_t        rd;
        out_t        o;
        logic [15:0] w;
        e.idx = model_idx(pxl_in, prio_m, gfx_en);
        e.hb  = LHBL;
        e.vb  = LVBL;
        idxq.push_back(e);
        if (hb_last_m && !LHBL) prio_m = prio;
        hb_last_m = LHBL;
        if (idxq.size() == 2) begin
            rd = idxq.pop_front();
            w  = shadow[rd.idx];
            o.hb = rd.hb;
            o.vb = rd.vb;
            o.r  = (rd.hb && rd.vb) ? w[4:0]   : 5'd0;
            o.g  = (rd.hb && rd.vb) ? w[9:5]   : 5'd0;
            o.b  = (rd.hb && rd.vb) ? w[14:10] : 5'd0;
            rgbq.push_back(o);
        end
        if (do_wr) begin
            pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b1;
            cpu_addr = wa; cpu_dout = wd;
            if (wa[0]) shadow[wa[9:1]][15:8] = wd;
            else       shadow[wa[9:1]][7:0]  = wd;
        end
        pxl_cen = 1'b1;
        @(posedge clk); #1;
        pxl_cen = 1'b0; pal_cs = 1'b0; cpu_cen = 1'b0; cpu_rnw = 1'b1;
        @(posedge clk); #1;
        n_tick++;
        if (rgbq.size() == 2) begin
            o = rgbq.pop_front();
            chk($sformatf("t%0d_red", n_tick),   32'(red),      32'(o.r));
            chk($sformatf("t%0d_green", n_tick), 32'(green),    32'(o.g));
            chk($sformatf("t%0d_blue", n_tick),  32'(blue),     32'(o.b));
            chk($sformatf("t%0d_hbdly", n_tick), 32'(LHBL_dly), 32'(o.hb));
            chk($sformatf("t%0d_vbdly", n_tick), 32'(LVBL_dly), 32'(o.vb));
            $display("tick %0d rgb=%0d,%0d,%0d hb=%0b vb=%0b", n_tick, red, green, blue,
                     LHBL_dly, LVBL_dly);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 10'd0, 8'd0);
    endtask

    task automatic cpu_write(input logic [9:0] a, input logic [7:0] d);
        pal_cs = 1'b1; cpu_rnw = 1'b0; cpu_cen = 1'b1; cpu_addr = a; cpu_dout = d;
        @(posedge clk); #1;
        pal_cs = 1'b0; cpu_cen = 1'b0; cpu_rnw = 1'b1;
        if (a[0]) shadow[a[9:1]][15:8] = d;
        else      shadow[a[9:1]][7:0]  = d;
    endtask

    task automatic cpu_read(input logic [9:0] a);
        logic [7:0] exp_b;
        exp_b = a[0] ? shadow[a[9:1]][15:8] : shadow[a[9:1]][7:0];
        pal_cs = 1'b1; cpu_rnw = 1'b1; cpu_addr = a;
        @(posedge clk); #1;
        pal_cs = 1'b0;
        chk($sformatf("rd_%0h", a), 32'(pal_dout), 32'(exp_b));
        cpu_addr = a ^ 10'h155;
        @(posedge clk); #1;
        chk($sformatf("rd_hold_%0h", a), 32'(pal_dout), 32'(exp_b));
        $display("cpu read addr=%0h data=%0h", a, pal_dout);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] wv;
        rst = 1'b1; pxl_cen = 1'b0; LHBL = 1'b0; LVBL = 1'b0;
        pxl_in = '0; prio = 4'b0100; gfx_en = 2'b11;
        cpu_cen = 1'b0; pal_cs = 1'b0; cpu_rnw = 1'b1; cpu_addr = '0; cpu_dout = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_red", 32'(red), 0);
        chk("rst_green", 32'(green), 0);
        chk("rst_blue", 32'(blue), 0);
        chk("rst_pal_dout", 32'(pal_dout), 0);
        chk("rst_hbdly", 32'(LHBL_dly), 0);
        chk("rst_vbdly", 32'(LVBL_dly), 0);
        rst = 1'b0;

        // Fill the palette with a varied pattern so every read is defined.
        for (int w = 0; w < 512; w++) begin
            wv = 16'(w * 16'h2F3B) ^ 16'h5A5A;
            cpu_write(10'(w*2), wv[7:0]);
            cpu_write(10'(w*2+1), wv[15:8]);
        end
        cpu_write(10'h000, 8'h1F);
        cpu_write(10'h001, 8'h7C);
        cpu_read(10'h000);
        cpu_read(10'h001);
        chk("word0", 32'(shadow[0]), 32'h7C1F);
        cpu_write(10'h02A, 8'hFF);
        cpu_write(10'h02B, 8'h7F);
        cpu_write(10'h146, 8'h34);
        cpu_write(10'h147, 8'h12);
        cpu_read(10'h02B);

        model_reset();
        LHBL = 1'b1; LVBL = 1'b1;
        pxl_in = {7'h23, 7'h15};
        ticks(4);                          // word 0x15 -> white
        pxl_in = {7'h23, 7'h10};
        ticks(3);                          // layer0 transparent -> word 0xA3
        pxl_in = {7'h20, 7'h10};
        ticks(3);                          // backdrop word 0 -> 31,0,31
        gfx_en = 2'b10; pxl_in = {7'h23, 7'h15};
        ticks(3);                          // layer0 disabled -> layer1
        gfx_en = 2'b11;
        prio = 4'b0001;
        ticks(3);                          // mid-line change: layer0 still on top
        LHBL = 1'b0; ticks(2);
        LHBL = 1'b1; ticks(4);             // new line: layer1 on top
        prio = 4'b0000;
        LHBL = 1'b0; ticks(2);
        LHBL = 1'b1; ticks(4);             // equal ranks -> layer0
        tick(1'b0, 10'd0, 8'd0);
        tick(1'b1, 10'h02A, 8'h00);        // collision on word 0x15
        ticks(4);
        LVBL = 1'b0; ticks(4);
        LVBL = 1'b1; ticks(4);

        // Asynchronous reset mid-line with a non-black pixel on the outputs.
        chk("pre_rst_rgb_nonzero", 32'({red, green, blue} != 15'd0), 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_red", 32'(red), 0);
        chk("arst_green", 32'(green), 0);
        chk("arst_blue", 32'(blue), 0);
        chk("arst_pal_dout", 32'(pal_dout), 0);
        chk("arst_hbdly", 32'(LHBL_dly), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        ticks(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
